// File: rtl/hamming_serial_rx_if.sv
// hamming_serial_rx_if: serial bit stream in, decoded word and status out
interface hamming_serial_rx_if;
   logic       enable;
   logic       frame_start;
   logic       serial_in;
   logic       data_ready;
   logic [7:0] data_out;
   logic       data_valid;
   logic       err_corrected;
   logic       err_uncorr;
   logic [3:0] err_pos;
   logic       overrun;
   modport master (
      output enable, frame_start, serial_in, data_ready,
      input  data_out, data_valid, err_corrected, err_uncorr, err_pos, overrun
   );
   modport slave (
      input  enable, frame_start, serial_in, data_ready,
      output data_out, data_valid, err_corrected, err_uncorr, err_pos, overrun
   );
endinterface

// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: shifts in a Hamming(12,8) codeword LSB-first, corrects single-bit errors
// and holds the decoded byte with its error flags until the consumer takes it
module hamming_serial_rx (
   input logic                  clk,
   input logic                  rst,
   hamming_serial_rx_if.slave   io_bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DECODE, VALID} state_t;
   state_t      r_state, w_next;
   logic [3:0]  r_cnt;
   logic [11:0] r_code;
   logic [7:0]  r_data;
   logic        r_valid, r_corr, r_uncorr, r_ovr;
   logic [3:0]  r_pos;
   logic        w_start, w_shift, w_in_range;
   logic [3:0]  w_syn;
   logic [11:0] w_fix;
   assign w_start = io_bus.enable & io_bus.frame_start;
   assign w_shift = (r_state == IDLE && w_start) || (r_state == SHIFT && io_bus.enable && r_cnt != 4'd12);
   // r_code[0] holds position 1 once all twelve bits are in
   always_comb begin
      w_syn = 4'd0;
      for (int i = 0; i < 12; i++) if (r_code[i]) w_syn = w_syn ^ 4'(i + 1);
   end
   assign w_in_range = w_syn != 4'd0 && w_syn <= 4'd12;
   assign w_fix = r_code ^ (w_in_range ? 12'd1 << (w_syn - 4'd1) : 12'd0);
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE && w_start)       ? SHIFT  :
               (r_state == SHIFT && r_cnt == 4'd12) ? DECODE :
               (r_state == DECODE)                  ? VALID  :
               (r_state == VALID && io_bus.data_ready) ? IDLE : r_state;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_code   <= 12'd0;
         r_data   <= 8'd0;
         r_valid  <= 1'b0;
         r_corr   <= 1'b0;
         r_uncorr <= 1'b0;
         r_pos    <= 4'd0;
         r_ovr    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_shift) begin
            r_code <= {io_bus.serial_in, r_code[11:1]};
            r_cnt  <= (r_state == IDLE) ? 4'd1 : r_cnt + 4'd1;
         end
         if (r_state == DECODE) begin
            r_data   <= {w_fix[11:8], w_fix[6:4], w_fix[2]};
            r_valid  <= 1'b1;
            r_corr   <= w_in_range;
            r_uncorr <= w_syn >= 4'd13;
            r_pos    <= w_syn;
         end
         if (r_state == VALID && io_bus.data_ready) begin
            r_valid  <= 1'b0;
            r_corr   <= 1'b0;
            r_uncorr <= 1'b0;
            r_pos    <= 4'd0;
         end
         if (r_state == VALID && w_start) r_ovr <= 1'b1;
      end
   end
   assign io_bus.data_out      = r_data;
   assign io_bus.data_valid    = r_valid;
   assign io_bus.err_corrected = r_corr;
   assign io_bus.err_uncorr    = r_uncorr;
   assign io_bus.err_pos       = r_pos;
   assign io_bus.overrun       = r_ovr;
endmodule
